qdec_cabac_ctu_sched: RTL and testbench
=======================================

// Module: qdec_cabac_ctu_sched
// PURPOSE
//  CTU raster scheduler that sits directly downstream of the CABAC control register block.
//  - On the one-cycle cabac_start pulse, latches the picture geometry fields that are carried on the register outputs.
//  - Derives the picture size in CTBs.
//  - Issues one CTU job at a time to the CABAC decode core over a valid/ready handshake.
//  - Waits for ctu_done on each job, then signals pic_done after the last CTU.
// PARAMETERS
//  CNT_W   12  width of CTB column/row counters (supports 65535/16 -> 4096 CTBs per dimension)
//  ADDR_W  24  width of CTU raster address (CNT_W*2)
// PORTS
//  clk              in   1       system clock
//  rst_n            in   1       synchronous active-low reset
//  cabac_start      in   1       one-cycle start pulse from the register block
//  abort            in   1       level; forces return to IDLE
//  pic_width_luma   in   16      pic_width_in_luma_samples (SPS field)
//  pic_height_luma  in   16      pic_height_in_luma_samples (SPS field)
//  log2_ctb_size    in   3       CtbLog2SizeY; legal values 4..6
//  ctu_valid        out  1       CTU job valid
//  ctu_ready        in   1       decode core accepts the job
//  ctu_x            out  CNT_W   CTB column of the job
//  ctu_y            out  CNT_W   CTB row of the job
//  ctu_addr         out  ADDR_W  raster address: ctu_y*pic_w_ctb + ctu_x
//  ctu_first_in_row out  1       ctu_x==0
//  ctu_last_in_pic  out  1       job is the final CTU of the picture
//  ctu_done         in   1       one-cycle pulse: core finished the accepted CTU
//  busy             out  1       state != IDLE
//  pic_done         out  1       one-cycle pulse after the last ctu_done
//  err_cfg          out  1       one-cycle pulse: illegal geometry at start
// BEHAVIOUR
//  - Reset: all outputs 0; state=IDLE; all counters 0.
//  - Geometry is sampled only on the cabac_start cycle in IDLE. Later input changes have no effect until the next start.
//  - State machine:
//    - IDLE->CALC on cabac_start. In any other state, cabac_start is ignored.
//    - CALC (1 cycle):
//      - pic_w_ctb=(w+(1<<l)-1)>>l and pic_h_ctb likewise, computed in 17-bit arithmetic so there is no overflow at 65535.
//      - Sets x=y=0 and addr=0.
//      - If l<4, l>6, w==0 or h==0: err_cfg=1 for 1 cycle, then IDLE. No ctu_valid is issued.
//      - Otherwise ->ISSUE.
//    - ISSUE: ctu_valid=1.
//      - ctu_x, ctu_y, ctu_addr and flags are registered and stable while valid && !ready.
//      - On valid && ready: ->WAIT and ctu_valid drops in the next cycle.
//    - WAIT: waits for ctu_done.
//      - If not last: x++. When x==pic_w_ctb-1, wrap x=0 and y++. addr++. Then ->ISSUE.
//      - If last: ->DONE.
//    - DONE: pic_done=1 for exactly 1 cycle, then IDLE.
//  - Latency:
//    - start@N -> CALC@N+1 -> ctu_valid@N+2.
//    - ctu_done@M -> next ctu_valid@M+1.
//    - Last ctu_done@M -> pic_done@M+1.
//  - ctu_done outside WAIT is ignored. ctu_done in the same cycle as the accept is ignored: done is only counted from WAIT.
//  - abort has priority over every transition. From any state, next cycle: IDLE with ctu_valid=0, and no pic_done or err_cfg.
//  - Synchronous reset mid-picture behaves exactly like abort plus clearing all counters.
//  - Single-CTU picture (1x1): first and last flags are both set on the same job.
// TESTING
//  - 64x64, l=6: start -> single job x=0,y=0,addr=0, first=last=1; ctu_done -> pic_done next cycle. busy spans start+1..pic_done.
//  - 1920x1080, l=6, ready held high: 30x17 grid gives 510 jobs in raster order. The last job is x=29,y=16,addr=509,last=1.
//  - 100x50, l=4: 7x4 grid gives 28 jobs. The wrap occurs at x=6->0 with y increment, and first_in_row is set at addr 0,7,14,21.
//  - l=3 or w=0: err_cfg pulses at start+1, with no ctu_valid, busy returns to 0, and no pic_done.
//  - ready held low for 5 cycles in ISSUE: valid, x, y and addr are held stable. A start pulse in mid-picture is ignored.
//  - abort asserted in WAIT at job 3: IDLE next cycle with no pic_done. A new start restarts the picture from addr 0.

Source files
------------

// File: rtl/qdec_cabac_ctu_sched.sv
// CTU raster scheduler: latches picture geometry on cabac_start, then issues one
// CTU job at a time over valid/ready and reports pic_done after the last ctu_done.
module qdec_cabac_ctu_sched #(
   parameter int CNT_W  = 12,
   parameter int ADDR_W = 24
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cabac_start,
   input  logic              abort,
   input  logic [15:0]       pic_width_luma,
   input  logic [15:0]       pic_height_luma,
   input  logic [2:0]        log2_ctb_size,
   output logic              ctu_valid,
   input  logic              ctu_ready,
   output logic [CNT_W-1:0]  ctu_x,
   output logic [CNT_W-1:0]  ctu_y,
   output logic [ADDR_W-1:0] ctu_addr,
   output logic              ctu_first_in_row,
   output logic              ctu_last_in_pic,
   input  logic              ctu_done,
   output logic              busy,
   output logic              pic_done,
   output logic              err_cfg
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CALC,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t              state_q;
   logic [15:0]         w_q, h_q;
   logic [2:0]          l_q;
   logic [CNT_W:0]      pw_q, ph_q;
   logic [CNT_W-1:0]    x_q, y_q;
   logic [ADDR_W-1:0]   addr_q;
   logic                valid_q, first_q, last_q, pic_done_q, err_q;

   logic [CNT_W:0]      pw_calc, ph_calc;
   logic                geom_bad;
   logic                x_wrap;
   logic [CNT_W-1:0]    x_d, y_d;
   logic                last_d;

   // Ceiling division done in 17 bits so a 65535-sample dimension cannot overflow.
   always_comb begin
      pw_calc  = (CNT_W+1)'(({1'b0, w_q} + ((17'd1 << l_q) - 17'd1)) >> l_q);
      ph_calc  = (CNT_W+1)'(({1'b0, h_q} + ((17'd1 << l_q) - 17'd1)) >> l_q);
      geom_bad = (log2_ctb_size < 3'd4) || (log2_ctb_size > 3'd6) ||
                 (pic_width_luma == '0) || (pic_height_luma == '0);
      x_wrap   = ({1'b0, x_q} == (pw_q - (CNT_W+1)'(1)));
      x_d      = x_wrap ? '0 : x_q + CNT_W'(1);
      y_d      = x_wrap ? y_q + CNT_W'(1) : y_q;
      last_d   = ({1'b0, x_d} == (pw_q - (CNT_W+1)'(1))) &&
                 ({1'b0, y_d} == (ph_q - (CNT_W+1)'(1)));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         w_q        <= '0;
         h_q        <= '0;
         l_q        <= '0;
         pw_q       <= '0;
         ph_q       <= '0;
         x_q        <= '0;
         y_q        <= '0;
         addr_q     <= '0;
         valid_q    <= 1'b0;
         first_q    <= 1'b0;
         last_q     <= 1'b0;
         pic_done_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         pic_done_q <= 1'b0;
         err_q      <= 1'b0;
         if (abort) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (cabac_start) begin
                     w_q     <= pic_width_luma;
                     h_q     <= pic_height_luma;
                     l_q     <= log2_ctb_size;
                     // Legality is judged on the start edge so err_cfg lands in the CALC cycle.
                     err_q   <= geom_bad;
                     state_q <= S_CALC;
                  end
               end
               S_CALC: begin
                  x_q     <= '0;
                  y_q     <= '0;
                  addr_q  <= '0;
                  pw_q    <= pw_calc;
                  ph_q    <= ph_calc;
                  first_q <= 1'b1;
                  last_q  <= (pw_calc == (CNT_W+1)'(1)) && (ph_calc == (CNT_W+1)'(1));
                  if (err_q) begin
                     state_q <= S_IDLE;
                  end else begin
                     valid_q <= 1'b1;
                     state_q <= S_ISSUE;
                  end
               end
               S_ISSUE: begin
                  if (ctu_ready) begin
                     valid_q <= 1'b0;
                     state_q <= S_WAIT;
                  end
               end
               S_WAIT: begin
                  if (ctu_done) begin
                     if (last_q) begin
                        pic_done_q <= 1'b1;
                        state_q    <= S_DONE;
                     end else begin
                        x_q     <= x_d;
                        y_q     <= y_d;
                        addr_q  <= addr_q + ADDR_W'(1);
                        first_q <= (x_d == '0);
                        last_q  <= last_d;
                        valid_q <= 1'b1;
                        state_q <= S_ISSUE;
                     end
                  end
               end
               S_DONE: state_q <= S_IDLE;
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign ctu_valid        = valid_q;
   assign ctu_x            = x_q;
   assign ctu_y            = y_q;
   assign ctu_addr         = addr_q;
   assign ctu_first_in_row = first_q;
   assign ctu_last_in_pic  = last_q;
   assign busy             = (state_q != S_IDLE);
   assign pic_done         = pic_done_q;
   assign err_cfg          = err_q;

endmodule

// File: tb/tb_qdec_cabac_ctu_sched.sv
// Scoreboard bench for the CTU scheduler: stimulus queues expected jobs/events,
// a negedge monitor pops and compares on every accept, pic_done and err_cfg.
module tb_qdec_cabac_ctu_sched;

   localparam int CNT_W  = 12;
   localparam int ADDR_W = 24;
   localparam int K_JOB = 0, K_PIC = 1, K_ERR = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              cabac_start = 1'b0;
   logic              abort = 1'b0;
   logic [15:0]       pic_width_luma = '0;
   logic [15:0]       pic_height_luma = '0;
   logic [2:0]        log2_ctb_size = '0;
   logic              ctu_valid;
   logic              ctu_ready = 1'b0;
   logic [CNT_W-1:0]  ctu_x, ctu_y;
   logic [ADDR_W-1:0] ctu_addr;
   logic              ctu_first_in_row, ctu_last_in_pic;
   logic              ctu_done = 1'b0;
   logic              busy, pic_done, err_cfg;

   typedef struct {
      int kind;
      int x;
      int y;
      int addr;
      int first;
      int last;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   done_dly = 0;
   int   block_addr = -1;

   qdec_cabac_ctu_sched #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .cabac_start(cabac_start), .abort(abort),
      .pic_width_luma(pic_width_luma), .pic_height_luma(pic_height_luma),
      .log2_ctb_size(log2_ctb_size), .ctu_valid(ctu_valid), .ctu_ready(ctu_ready),
      .ctu_x(ctu_x), .ctu_y(ctu_y), .ctu_addr(ctu_addr),
      .ctu_first_in_row(ctu_first_in_row), .ctu_last_in_pic(ctu_last_in_pic),
      .ctu_done(ctu_done), .busy(busy), .pic_done(pic_done), .err_cfg(err_cfg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // Expected jobs of a pw x ph grid in raster order (first n of them), plus pic_done if complete.
   task automatic push_grid(input int pw, input int ph, input int n);
      exp_t e;
      int   k = 0;
      for (int y = 0; y < ph; y++) begin
         for (int x = 0; x < pw; x++) begin
            if (k < n) begin
               e.kind = K_JOB; e.x = x; e.y = y; e.addr = y * pw + x;
               e.first = (x == 0); e.last = (x == pw - 1) && (y == ph - 1);
               exp_q.push_back(e);
            end
            k++;
         end
      end
      if (n >= pw * ph) begin
         e.kind = K_PIC; e.x = 0; e.y = 0; e.addr = 0; e.first = 0; e.last = 0;
         exp_q.push_back(e);
      end
   endtask

   task automatic push_err();
      exp_t e;
      e.kind = K_ERR; e.x = 0; e.y = 0; e.addr = 0; e.first = 0; e.last = 0;
      exp_q.push_back(e);
   endtask

   // Geometry is scrambled right after the start cycle to prove it was latched.
   task automatic start_pic(input int w, input int h, input int l);
      @(posedge clk); #1;
      pic_width_luma  = 16'(w);
      pic_height_luma = 16'(h);
      log2_ctb_size   = 3'(l);
      cabac_start     = 1'b1;
      @(posedge clk); #1;
      cabac_start     = 1'b0;
      pic_width_luma  = 16'hFFFF;
      pic_height_luma = 16'h0001;
      log2_ctb_size   = 3'd7;
   endtask

   task automatic wait_idle(input int bound);
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      chk("idle_timeout", {31'd0, busy}, 0);
   endtask

   // Decode-core model: pulses ctu_done done_dly cycles after each accept.
   initial begin
      int a;
      forever begin
         @(negedge clk);
         if (rst_n && ctu_valid && ctu_ready && !abort) begin
            a = int'(ctu_addr);
            @(posedge clk); #1;
            for (int i = 0; i < done_dly; i++) begin
               @(posedge clk); #1;
            end
            if (a != block_addr) begin
               ctu_done = 1'b1;
               @(posedge clk); #1;
               ctu_done = 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && ((ctu_valid && ctu_ready) || pic_done || err_cfg)) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_event", {29'd0, ctu_valid, pic_done, err_cfg}, 0);
         end else begin
            e = exp_q.pop_front();
            if (ctu_valid && ctu_ready) begin
               chk("job_kind", K_JOB, e.kind);
               chk("job_x", 32'(ctu_x), e.x);
               chk("job_y", 32'(ctu_y), e.y);
               chk("job_addr", 32'(ctu_addr), e.addr);
               chk("job_first", 32'(ctu_first_in_row), e.first);
               chk("job_last", 32'(ctu_last_in_pic), e.last);
            end else if (pic_done) begin
               chk("pic_done_kind", K_PIC, e.kind);
            end else begin
               chk("err_cfg_kind", K_ERR, e.kind);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int  cyc;
      bit  found;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", {31'd0, ctu_valid}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_pic_done", {31'd0, pic_done}, 0);
      chk("rst_err", {31'd0, err_cfg}, 0);
      chk("rst_xy_addr", {ctu_addr[7:0], 12'(ctu_x), 12'(ctu_y)}, 0);
      chk("rst_flags", {30'd0, ctu_first_in_row, ctu_last_in_pic}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // 64x64 l=6: single CTU, explicit cycle-by-cycle timing
      ctu_ready = 1'b1;
      done_dly  = 0;
      push_grid(1, 1, 1);
      start_pic(64, 64, 6);
      @(negedge clk);
      chk("calc_busy", {31'd0, busy}, 1);
      chk("calc_valid", {31'd0, ctu_valid}, 0);
      @(negedge clk);
      chk("issue_valid", {31'd0, ctu_valid}, 1);
      chk("single_first_last", {30'd0, ctu_first_in_row, ctu_last_in_pic}, 3);
      @(negedge clk);
      chk("wait_valid", {31'd0, ctu_valid}, 0);
      chk("wait_busy", {31'd0, busy}, 1);
      @(negedge clk);
      chk("done_pulse", {31'd0, pic_done}, 1);
      chk("done_busy", {31'd0, busy}, 1);
      @(negedge clk);
      chk("done_clear", {31'd0, pic_done}, 0);
      chk("idle_busy", {31'd0, busy}, 0);
      chk("sb_empty_1x1", exp_q.size(), 0);

      // 1920x1080 l=6: 30x17 grid, ready high, done immediate -> pic_done 1022 cycles after start
      push_grid(30, 17, 510);
      start_pic(1920, 1080, 6);
      cyc = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         cyc++;
         if (pic_done) break;
      end
      chk("hd_cycles", cyc, 1022);
      wait_idle(10);
      chk("sb_empty_hd", exp_q.size(), 0);

      // 100x50 l=4: 7x4 grid with a two-cycle core latency
      done_dly = 2;
      push_grid(7, 4, 28);
      start_pic(100, 50, 4);
      wait_idle(500);
      chk("sb_empty_7x4", exp_q.size(), 0);
      done_dly = 0;

      // Illegal geometry: l=3, then w=0, then l=7
      push_err();
      start_pic(64, 64, 3);
      @(negedge clk);
      chk("err_l3_pulse", {31'd0, err_cfg}, 1);
      @(negedge clk);
      chk("err_l3_clear", {30'd0, err_cfg, busy}, 0);
      push_err();
      start_pic(0, 64, 5);
      @(negedge clk);
      chk("err_w0_pulse", {31'd0, err_cfg}, 1);
      @(negedge clk);
      chk("err_w0_clear", {30'd0, err_cfg, busy}, 0);
      push_err();
      start_pic(64, 64, 7);
      repeat (4) @(negedge clk);
      chk("sb_empty_err", exp_q.size(), 0);

      // Ready held low 5 cycles; a mid-picture start must be ignored
      ctu_ready = 1'b0;
      push_grid(2, 2, 4);
      start_pic(32, 32, 4);
      found = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ctu_valid) begin found = 1; break; end
      end
      chk("hold_valid_seen", {31'd0, found}, 1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         cabac_start = (i == 2);
         if (i == 2) begin
            pic_width_luma  = 16'd1920;
            pic_height_luma = 16'd1080;
            log2_ctb_size   = 3'd4;
         end
         @(negedge clk);
         chk("hold_valid", {31'd0, ctu_valid}, 1);
         chk("hold_xy_addr", {ctu_addr[7:0], 12'(ctu_x), 12'(ctu_y)}, 0);
      end
      @(posedge clk); #1;
      cabac_start = 1'b0;
      ctu_ready   = 1'b1;
      wait_idle(100);
      chk("sb_empty_hold", exp_q.size(), 0);

      // Abort in WAIT of job 3 (4x4 grid), then restart from addr 0
      block_addr = 3;
      push_grid(4, 4, 4);
      start_pic(64, 64, 4);
      found = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (ctu_valid && ctu_addr == 3) begin found = 1; break; end
      end
      chk("abort_job3_seen", {31'd0, found}, 1);
      @(posedge clk); #1;
      abort = 1'b1;
      @(negedge clk);
      chk("abort_in_wait", {30'd0, busy, ctu_valid}, 2);
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      chk("abort_idle", {29'd0, busy, ctu_valid, pic_done}, 0);
      repeat (5) @(negedge clk);
      chk("sb_empty_abort", exp_q.size(), 0);
      block_addr = -1;
      push_grid(4, 4, 16);
      start_pic(64, 64, 4);
      wait_idle(200);
      chk("sb_empty_restart", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
